// File: rtl/asg_seq_pkg.sv
// asg_seq_pkg: shared state encoding, register-map constants and field widths for the ASG bank scheduler.
package asg_seq_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRIG, S_PLAY, S_DONE} state_t;

    localparam logic [7:0] BANK_BASE = 8'h00;
    localparam logic [7:0] LIST_BASE = 8'h40;
    localparam logic [7:0] CTRL_ADDR = 8'h60;

    localparam logic [2:0] F_START = 3'd0;
    localparam logic [2:0] F_END   = 3'd1;
    localparam logic [2:0] F_STEP  = 3'd2;
    localparam logic [2:0] F_SCALE = 3'd3;

    localparam int AMP_W   = 14;
    localparam int DC_W    = 14;
    localparam int REP_W   = 16;
    localparam int LBANK_W = 2;

endpackage

// File: rtl/asg_bank_sched_if.sv
// asg_bank_sched_if: register bus between the system-bus decoder (master) and the scheduler (slave).
// Signals: cfg_we_i write strobe, cfg_addr_i word address, cfg_wdata_i write data, cfg_rdata_o 1-cycle readback.
interface asg_bank_sched_if;

    logic        cfg_we_i;
    logic [7:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    modport master (output cfg_we_i, cfg_addr_i, cfg_wdata_i, input cfg_rdata_o);
    modport slave  (input cfg_we_i, cfg_addr_i, cfg_wdata_i, output cfg_rdata_o);

endinterface

// File: rtl/asg_bank_sched_regs.sv
// asg_seq_regs: bank parameter array, play list, CTRL register and registered readback mux.
// Ports: clk/rst, cfg bus (slave), idx list lookup index; lu_* are the combinational
// parameters of bank list[idx].bank plus that entry's repeat count; last/loop from CTRL.
module asg_seq_regs
    import asg_seq_pkg::*;
#(
    parameter int RSZ    = 14,
    parameter int N_BANK = 4,
    parameter int LSZ    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    asg_bank_sched_if.slave      cfg,
    input  logic [LSZ-1:0]       idx,
    output logic [RSZ+15:0]      lu_start,
    output logic [RSZ+15:0]      lu_end,
    output logic [RSZ+15:0]      lu_step,
    output logic [AMP_W-1:0]     lu_amp,
    output logic [DC_W-1:0]      lu_dc,
    output logic [REP_W-1:0]     lu_rep,
    output logic [LSZ-1:0]       last,
    output logic                 loop
);

    localparam int BI = N_BANK > 1 ? $clog2(N_BANK) : 1;
    localparam int NL = 2 ** LSZ;

    logic [RSZ+15:0]    b_start [N_BANK];
    logic [RSZ+15:0]    b_end   [N_BANK];
    logic [RSZ+15:0]    b_step  [N_BANK];
    logic [AMP_W-1:0]   b_amp   [N_BANK];
    logic [DC_W-1:0]    b_dc    [N_BANK];
    logic [REP_W-1:0]   l_rep   [NL];
    logic [LBANK_W-1:0] l_bank  [NL];

    logic [BI-1:0]  wb, lb;
    logic [LSZ-1:0] li;
    logic [2:0]     fld;
    logic           bank_hit, list_hit, ctrl_hit;
    logic [31:0]    rd;

    // Bank index keeps only the low bits, so bank numbers wrap mod N_BANK.
    assign wb       = cfg.cfg_addr_i[4 +: BI];
    assign li       = cfg.cfg_addr_i[LSZ-1:0];
    assign fld      = cfg.cfg_addr_i[2:0];
    assign bank_hit = cfg.cfg_addr_i[7:6] == BANK_BASE[7:6] && !cfg.cfg_addr_i[3];
    assign list_hit = cfg.cfg_addr_i[7:LSZ] == LIST_BASE[7:LSZ];
    assign ctrl_hit = cfg.cfg_addr_i == CTRL_ADDR;

    assign lb       = l_bank[idx][BI-1:0];
    assign lu_start = b_start[lb];
    assign lu_end   = b_end[lb];
    assign lu_step  = b_step[lb];
    assign lu_amp   = b_amp[lb];
    assign lu_dc    = b_dc[lb];
    assign lu_rep   = l_rep[idx];

    always_comb begin
        rd = '0;
        if (bank_hit)
            rd = fld == F_START ? 32'(b_start[wb]) :
                 fld == F_END   ? 32'(b_end[wb])   :
                 fld == F_STEP  ? 32'(b_step[wb])  :
                 fld == F_SCALE ? {2'b0, b_dc[wb], 2'b0, b_amp[wb]} : '0;
        else if (list_hit)
            rd = {l_rep[li], 14'b0, l_bank[li]};
        else if (ctrl_hit)
            rd = {23'b0, loop, 8'(last)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BANK; i++) begin
                b_start[i] <= '0;
                b_end[i]   <= '0;
                b_step[i]  <= '0;
                b_amp[i]   <= '0;
                b_dc[i]    <= '0;
            end
            for (int i = 0; i < NL; i++) begin
                l_rep[i]  <= '0;
                l_bank[i] <= '0;
            end
            last            <= '0;
            loop            <= 1'b0;
            cfg.cfg_rdata_o <= '0;
        end else begin
            cfg.cfg_rdata_o <= rd;
            if (cfg.cfg_we_i && bank_hit)
                case (fld)
                    F_START: b_start[wb] <= cfg.cfg_wdata_i[RSZ+15:0];
                    F_END:   b_end[wb]   <= cfg.cfg_wdata_i[RSZ+15:0];
                    F_STEP:  b_step[wb]  <= cfg.cfg_wdata_i[RSZ+15:0];
                    F_SCALE: begin
                        b_amp[wb] <= cfg.cfg_wdata_i[AMP_W-1:0];
                        b_dc[wb]  <= cfg.cfg_wdata_i[16 +: DC_W];
                    end
                    default: ;
                endcase
            if (cfg.cfg_we_i && list_hit) begin
                l_rep[li]  <= cfg.cfg_wdata_i[31:16];
                l_bank[li] <= cfg.cfg_wdata_i[LBANK_W-1:0];
            end
            if (cfg.cfg_we_i && ctrl_hit) begin
                loop <= cfg.cfg_wdata_i[8];
                last <= cfg.cfg_wdata_i[LSZ-1:0];
            end
        end
    end

endmodule

// File: rtl/asg_bank_sched.sv
// asg_bank_sched: play-list scheduler for one ASG channel; walks the list, shadows the active bank
// into act_* at each LOAD and resets/re-triggers the channel at every entry change.
// Ports: dac_clk_i/dac_rst_i, cfg register bus, ctl_start_i/ctl_stop_i pulses, ch_done_i end-of-pass,
// ch_rst_o/ch_trig_o channel control, act_* active parameters, seq_busy_o/seq_idx_o/seq_done_o status.
module asg_bank_sched
    import asg_seq_pkg::*;
#(
    parameter int RSZ    = 14,
    parameter int N_BANK = 4,
    parameter int LSZ    = 3
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    asg_bank_sched_if.slave cfg,
    input  logic            ctl_start_i,
    input  logic            ctl_stop_i,
    input  logic            ch_done_i,
    output logic            ch_rst_o,
    output logic            ch_trig_o,
    output logic [RSZ+15:0] act_start_o,
    output logic [RSZ+15:0] act_end_o,
    output logic [RSZ+15:0] act_step_o,
    output logic [13:0]     act_amp_o,
    output logic [13:0]     act_dc_o,
    output logic            seq_busy_o,
    output logic [LSZ-1:0]  seq_idx_o,
    output logic            seq_done_o
);

    state_t           state, state_nxt;
    logic [LSZ-1:0]   idx_nxt, last;
    logic [REP_W-1:0] rep_cnt, cnt_nxt, lu_rep, rep_eff;
    logic [RSZ+15:0]  lu_start, lu_end, lu_step;
    logic [AMP_W-1:0] lu_amp;
    logic [DC_W-1:0]  lu_dc;
    logic             loop, rep_end;

    asg_seq_regs #(.RSZ(RSZ), .N_BANK(N_BANK), .LSZ(LSZ)) u_regs (
        .clk      (dac_clk_i),
        .rst      (dac_rst_i),
        .cfg      (cfg),
        .idx      (seq_idx_o),
        .lu_start (lu_start),
        .lu_end   (lu_end),
        .lu_step  (lu_step),
        .lu_amp   (lu_amp),
        .lu_dc    (lu_dc),
        .lu_rep   (lu_rep),
        .last     (last),
        .loop     (loop)
    );

    // Comparing before incrementing keeps rep_cnt below rep, so 16 bits never overflow.
    assign rep_eff = lu_rep == '0 ? REP_W'(1) : lu_rep;
    assign rep_end = {1'b0, rep_cnt} + 17'd1 >= {1'b0, rep_eff};

    assign ch_rst_o   = state inside {S_IDLE, S_LOAD, S_DONE};
    assign ch_trig_o  = state == S_TRIG;
    assign seq_busy_o = state inside {S_LOAD, S_TRIG, S_PLAY};
    assign seq_done_o = state == S_DONE;

    always_comb begin
        state_nxt = state;
        idx_nxt   = seq_idx_o;
        cnt_nxt   = rep_cnt;
        case (state)
            S_IDLE: if (ctl_start_i) begin
                state_nxt = S_LOAD;
                idx_nxt   = '0;
            end
            S_LOAD: begin
                state_nxt = S_TRIG;
                cnt_nxt   = '0;
            end
            S_TRIG: state_nxt = S_PLAY;
            S_PLAY: if (ch_done_i) begin
                cnt_nxt = rep_cnt + 1'b1;
                if (rep_end) begin
                    state_nxt = (seq_idx_o < last || loop) ? S_LOAD : S_DONE;
                    idx_nxt   = seq_idx_o < last ? seq_idx_o + 1'b1 : loop ? '0 : seq_idx_o;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (ctl_stop_i) begin
            state_nxt = S_IDLE;
            idx_nxt   = seq_idx_o;
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state       <= S_IDLE;
            seq_idx_o   <= '0;
            rep_cnt     <= '0;
            act_start_o <= '0;
            act_end_o   <= '0;
            act_step_o  <= '0;
            act_amp_o   <= '0;
            act_dc_o    <= '0;
        end else begin
            state     <= state_nxt;
            seq_idx_o <= idx_nxt;
            rep_cnt   <= cnt_nxt;
            if (state == S_LOAD) begin
                act_start_o <= lu_start;
                act_end_o   <= lu_end;
                act_step_o  <= lu_step;
                act_amp_o   <= lu_amp;
                act_dc_o    <= lu_dc;
            end
        end
    end

endmodule

// File: tb/tb_asg_bank_sched.sv
// tb_asg_bank_sched: self-checking bench for asg_bank_sched (register vectors plus play-list sequences).
module tb_asg_bank_sched;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [29:0] s, e, st;
        logic [13:0] a, d;
    } act_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctl_start = 1'b0, ctl_stop = 1'b0, ch_done = 1'b0;
    logic        ch_rst, ch_trig, seq_busy, seq_done;
    logic [29:0] act_start, act_end, act_step;
    logic [13:0] act_amp, act_dc;
    logic [2:0]  seq_idx;

    int checks = 0, failures = 0, trig_n = 0, done_n = 0;
    int t0, d0;

    vec_t        tab [13];
    act_t        act_q [$];
    logic [31:0] rd_q [$];
    logic [29:0] m_s [4], m_e [4], m_st [4];
    logic [13:0] m_a [4], m_d [4];

    asg_bank_sched_if cfg_bus ();

    asg_bank_sched #(.RSZ(14), .N_BANK(4), .LSZ(3)) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .cfg         (cfg_bus),
        .ctl_start_i (ctl_start),
        .ctl_stop_i  (ctl_stop),
        .ch_done_i   (ch_done),
        .ch_rst_o    (ch_rst),
        .ch_trig_o   (ch_trig),
        .act_start_o (act_start),
        .act_end_o   (act_end),
        .act_step_o  (act_step),
        .act_amp_o   (act_amp),
        .act_dc_o    (act_dc),
        .seq_busy_o  (seq_busy),
        .seq_idx_o   (seq_idx),
        .seq_done_o  (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Every trigger must correspond to an expected bank load queued by the stimulus.
    task automatic mon();
        act_t x;
        if (ch_trig) begin
            trig_n++;
            if (act_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trig_unexpected got=1 exp=0");
            end else begin
                x = act_q.pop_front();
                chk("act_start", act_start, x.s);
                chk("act_end", act_end, x.e);
                chk("act_step", act_step, x.st);
                chk("act_amp", act_amp, x.a);
                chk("act_dc", act_dc, x.d);
            end
        end
        if (seq_done) done_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_bus.cfg_we_i    = 1'b1;
        cfg_bus.cfg_addr_i  = a;
        cfg_bus.cfg_wdata_i = d;
        if (a[7:6] == 2'b00 && !a[3])
            case (a[2:0])
                3'd0: m_s[a[5:4]] = d[29:0];
                3'd1: m_e[a[5:4]] = d[29:0];
                3'd2: m_st[a[5:4]] = d[29:0];
                3'd3: begin
                    m_a[a[5:4]] = d[13:0];
                    m_d[a[5:4]] = d[29:16];
                end
                default: ;
            endcase
        tick();
        cfg_bus.cfg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        cfg_bus.cfg_addr_i = a;
        rd_q.push_back(exp);
        tick();
        chk($sformatf("rdata_%02h", a), cfg_bus.cfg_rdata_o, rd_q.pop_front());
    endtask

    task automatic push_bank(input int b);
        act_q.push_back('{m_s[b], m_e[b], m_st[b], m_a[b], m_d[b]});
    endtask

    task automatic start_pulse();
        ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
    endtask

    task automatic done_pulse();
        ch_done = 1'b1;
        tick();
        ch_done = 1'b0;
    endtask

    initial begin
        tab[0]  = '{8'h00, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
        tab[1]  = '{8'h01, 32'h1234_5678, 32'h1234_5678};
        tab[2]  = '{8'h13, 32'hFFFF_FFFF, 32'h3FFF_3FFF};
        tab[3]  = '{8'h22, 32'hC000_0001, 32'h0000_0001};
        tab[4]  = '{8'h33, 32'h1234_5678, 32'h1234_1678};
        tab[5]  = '{8'h04, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[6]  = '{8'h08, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[7]  = '{8'h40, 32'hFFFF_FFFF, 32'hFFFF_0003};
        tab[8]  = '{8'h47, 32'h1234_ABCD, 32'h1234_0001};
        tab[9]  = '{8'h48, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[10] = '{8'h60, 32'hFFFF_FFFF, 32'h0000_0107};
        tab[11] = '{8'h61, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[12] = '{8'h80, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            m_s[i] = '0; m_e[i] = '0; m_st[i] = '0; m_a[i] = '0; m_d[i] = '0;
        end
        cfg_bus.cfg_we_i    = 1'b0;
        cfg_bus.cfg_addr_i  = '0;
        cfg_bus.cfg_wdata_i = '0;

        tick();
        tick();
        chk("rst_outs", {ch_rst, ch_trig, seq_busy, seq_done}, 4'b1000);
        chk("rst_idx", seq_idx, 0);
        chk("rst_act", {act_start, act_end, act_step, act_amp, act_dc}, 0);
        chk("rst_rdata", cfg_bus.cfg_rdata_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            wr(tab[i].addr, tab[i].wdata);
            rd(tab[i].addr, tab[i].exp);
        end

        // Single entry, rep 3
        wr(8'h00, 32'h0);
        wr(8'h01, 32'h3FFF_0000);
        wr(8'h02, 32'h0001_0000);
        wr(8'h03, 32'h0000_2000);
        wr(8'h40, 32'h0003_0000);
        wr(8'h60, 32'h0);
        t0 = trig_n;
        push_bank(0);
        start_pulse();
        chk("load_outs", {ch_rst, ch_trig, seq_busy}, 3'b101);
        tick();
        chk("trig_outs", {ch_rst, ch_trig}, 2'b01);
        chk("trig_end", act_end, 30'h3FFF_0000);
        chk("trig_amp", act_amp, 14'h2000);
        tick();
        chk("play_outs", {ch_rst, ch_trig, seq_busy}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            done_pulse();
            if (k < 2) begin
                chk("rep_wait", {seq_busy, seq_done}, 2'b10);
                tick();
            end
        end
        chk("done_pulse", {seq_busy, seq_done, ch_rst}, 3'b011);
        tick();
        chk("done_1cyc", {seq_done, ch_rst}, 2'b01);
        chk("trig_once", trig_n - t0, 1);

        // Two-entry loop with shadowed amp rewrite
        wr(8'h10, 32'h0000_0100);
        wr(8'h11, 32'h0200_0000);
        wr(8'h12, 32'h0000_8000);
        wr(8'h13, 32'h0123_0456);
        wr(8'h20, 32'h0000_0005);
        wr(8'h21, 32'h3FFF_FFFF);
        wr(8'h22, 32'h0002_0000);
        wr(8'h23, 32'h3FFF_0001);
        wr(8'h40, 32'h0002_0001);
        wr(8'h41, 32'h0001_0002);
        wr(8'h60, 32'h0000_0101);
        push_bank(1);
        start_pulse();
        tick();
        tick();
        done_pulse();
        chk("idx_a", {seq_idx, ch_rst}, {3'd0, 1'b0});
        tick();
        push_bank(2);
        done_pulse();
        chk("idx_b", {seq_idx, ch_rst}, {3'd1, 1'b1});
        tick();
        chk("chg1_trig", {ch_trig, ch_rst}, 2'b10);
        tick();
        push_bank(1);
        done_pulse();
        chk("idx_c", {seq_idx, ch_rst}, {3'd0, 1'b1});
        tick();
        chk("chg2_trig", {ch_trig, ch_rst}, 2'b10);
        tick();
        wr(8'h13, 32'h0123_0ABC);
        chk("shadow_hold", act_amp, 14'h0456);
        start_pulse();
        chk("start_ignored", {seq_busy, ch_rst, ch_trig}, 3'b100);
        done_pulse();
        tick();
        push_bank(2);
        done_pulse();
        tick();
        tick();
        push_bank(1);
        done_pulse();
        tick();
        chk("shadow_new", act_amp, 14'h0ABC);
        tick();

        // Stop collides with the done that would advance the entry
        done_pulse();
        tick();
        t0 = trig_n;
        d0 = done_n;
        ch_done  = 1'b1;
        ctl_stop = 1'b1;
        tick();
        ch_done  = 1'b0;
        ctl_stop = 1'b0;
        chk("stop_outs", {ch_rst, seq_busy, ch_trig, seq_done}, 4'b1000);
        tick();
        tick();
        chk("stop_no_trig", trig_n - t0, 0);
        chk("stop_no_done", done_n - d0, 0);

        // rep=0 advances on the first done
        wr(8'h40, 32'h0000_0000);
        wr(8'h60, 32'h0);
        push_bank(0);
        start_pulse();
        tick();
        tick();
        done_pulse();
        chk("rep0_done", {seq_done, seq_busy}, 2'b10);
        tick();

        // Asynchronous reset in the middle of PLAY
        wr(8'h40, 32'h0005_0000);
        push_bank(0);
        start_pulse();
        tick();
        tick();
        chk("pre_arst_end", act_end, 30'h3FFF_0000);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_outs", {ch_rst, ch_trig, seq_busy, seq_done}, 4'b1000);
        chk("arst_idx", seq_idx, 0);
        chk("arst_act", {act_start, act_end, act_amp}, 0);
        chk("arst_rdata", cfg_bus.cfg_rdata_o, 0);
        tick();
        rst = 1'b0;
        rd(8'h01, 32'h0);
        rd(8'h40, 32'h0);
        rd(8'h60, 32'h0);
        chk("act_q_empty", act_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
